uart_tx_ctrl: RTL and testbench

//  Frame controller for the UART transmitter, directly upstream of the 8-bit serializer.

---
 rtl/uart_tx_pkg.sv | 19 +
 rtl/uart_parity_calc.sv | 28 ++
 rtl/uart_tx_ctrl.sv | 136 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and line constants for the UART transmit frame controller.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_BIT  = 1'b1;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Registered parity generator; captures parity of the accepted byte so it is
// ready by the time the frame reaches its parity slot.
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    logic par_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= (^data) ^ (par_typ == PAR_ODD);
        end
    end

    assign par_bit = par_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start/data/parity/stop around the
// 8-bit serializer. Define UART_TX_TWO_STOP_EN to add the STOP2 port and 2-stop-bit frames.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
`ifdef UART_TX_TWO_STOP_EN
    input  logic                  STOP2,
`endif
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic [DATA_WIDTH-1:0] SER_P_DATA,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  busy_q;
    logic                  par_bit;
    logic                  accept;
    logic                  stop_last;
    logic                  tx_out_d;
    logic                  ser_en_d;

`ifdef UART_TX_TWO_STOP_EN
    logic stop2_q;
    logic stop_cnt_q, stop_cnt_d;

    // Counter marks the second stop cycle; only meaningful when STOP2 was latched.
    assign stop_last  = ~stop2_q | stop_cnt_q;
    assign stop_cnt_d = (state_q == STOP) && !stop_last;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
        end else begin
            stop_cnt_q <= stop_cnt_d;
            if (accept) begin
                stop2_q <= STOP2;
            end
        end
    end
`else
    assign stop_last = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        ser_en_d = 1'b0;
        tx_out_d = IDLE_BIT;
        case (state_q)
            IDLE: begin
                if (DATA_VALID) begin
                    accept  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                tx_out_d = START_BIT;
                ser_en_d = 1'b1;
                state_d  = DATA;
            end
            DATA: begin
                tx_out_d = ser_data;
                ser_en_d = ~ser_done;
                if (ser_done) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                tx_out_d = par_bit;
                state_d  = STOP;
            end
            STOP: begin
                tx_out_d = STOP_BIT;
                // Final stop cycle doubles as an accept slot for back-to-back frames.
                if (stop_last) begin
                    if (DATA_VALID) begin
                        accept  = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            data_q   <= '0;
            par_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            if (accept) begin
                data_q   <= P_DATA;
                par_en_q <= PAR_EN;
            end
        end
    end

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .CLK     (CLK),
        .RST     (RST),
        .load    (accept),
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .par_bit (par_bit)
    );

    assign SER_P_DATA = data_q;
    assign ser_en     = ser_en_d;
    assign TX_OUT     = tx_out_d;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with a behavioural serializer and a
// frame-queue reference model. Honours UART_TX_TWO_STOP_EN when defined.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STOP2;
    logic       ser_done;
    logic       ser_data;
    logic [7:0] SER_P_DATA;
    logic       ser_en;
    logic       TX_OUT;
    logic       BUSY;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    uart_tx_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
`ifdef UART_TX_TWO_STOP_EN
        .STOP2      (STOP2),
`endif
        .ser_done   (ser_done),
        .ser_data   (ser_data),
        .SER_P_DATA (SER_P_DATA),
        .ser_en     (ser_en),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY)
    );

    // Serializer: registers bit idx on each enable; done while bit 7 is on its output.
    logic [3:0] ser_idx;
    assign ser_done = (ser_idx == 4'd8);
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ser_idx  <= 4'd0;
            ser_data <= 1'b0;
        end else if (ser_done) begin
            ser_idx <= 4'd0;
        end else if (ser_en) begin
            ser_data <= SER_P_DATA[ser_idx[2:0]];
            ser_idx  <= ser_idx + 4'd1;
        end
    end

    // Reference model: queue of {ser_en, line} pairs still to appear, one per cycle.
    logic [1:0] exp_q[$];
    logic [7:0] exp_byte = 8'h00;
    logic       exp_busy = 1'b0;
    logic       accepted;
    logic       line_log[$];
    int         busy_cnt;
    int         en_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] b, input logic pe, input logic pt,
                              input logic s2);
        exp_q.push_back(2'b10);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({(i < 7) ? 1'b1 : 1'b0, b[i]});
        end
        if (pe) begin
            exp_q.push_back({1'b0, 1'(($countones(b) + int'(pt)) % 2)});
        end
        exp_q.push_back(2'b01);
        if (s2) begin
            exp_q.push_back(2'b01);
        end
    endtask

    task automatic tick();
        logic [1:0] cur;
        logic       s2;
        @(posedge CLK);
`ifdef UART_TX_TWO_STOP_EN
        s2 = STOP2;
`else
        s2 = 1'b0;
`endif
        accepted = 1'b0;
        if (!RST && exp_q.size() == 0 && DATA_VALID) begin
            push_frame(P_DATA, PAR_EN, PAR_TYP, s2);
            exp_byte = P_DATA;
            accepted = 1'b1;
        end
        if (!RST && exp_q.size() != 0) begin
            cur      = exp_q.pop_front();
            exp_busy = 1'b1;
        end else begin
            cur      = 2'b01;
            exp_busy = 1'b0;
        end
        #1;
        check_val("tx_out", 32'(TX_OUT), 32'(cur[0]));
        check_val("ser_en", 32'(ser_en), 32'(cur[1]));
        check_val("busy", 32'(BUSY), 32'(exp_busy));
        check_val("ser_p_data", 32'(SER_P_DATA), 32'(exp_byte));
        line_log.push_back(TX_OUT);
        if (BUSY) busy_cnt++;
        if (ser_en) en_cnt++;
    endtask

    task automatic clear_log();
        line_log.delete();
        busy_cnt = 0;
        en_cnt   = 0;
    endtask

    task automatic set_in(input logic [7:0] d, input logic v, input logic pe, input logic pt,
                          input logic s2);
        P_DATA     = d;
        DATA_VALID = v;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        STOP2      = s2;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic assert_reset();
        RST = 1'b1;
        #1;
        exp_q.delete();
        exp_byte = 8'h00;
        exp_busy = 1'b0;
        check_val("rst_tx_out", 32'(TX_OUT), 32'd1);
        check_val("rst_busy", 32'(BUSY), 32'd0);
        check_val("rst_ser_en", 32'(ser_en), 32'd0);
        check_val("rst_ser_p_data", 32'(SER_P_DATA), 32'd0);
    endtask

    initial begin
        logic [9:0]  got10;
        logic [7:0]  seq3[3];
        int          k;

        set_in(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        #1;
        assert_reset();
        #10;
        RST = 1'b0;
        run_idle(2);

        // 1: 0xA5, no parity, single-cycle valid
        set_in(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_log();
        tick();
        set_in(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1);
        run_idle(11);
        for (int i = 0; i < 10; i++) got10[i] = line_log[i];
        check_val("t1_line_seq", 32'(got10), 32'h34A);
        check_val("t1_busy_cycles", 32'(busy_cnt), 32'd10);
        check_val("t1_ser_en_cycles", 32'(en_cnt), 32'd8);

        // 2: 0x03 with even then odd parity
        for (int t = 0; t < 2; t++) begin
            set_in(8'h03, 1'b1, 1'b1, 1'(t), 1'b0);
            clear_log();
            tick();
            set_in(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
            run_idle(12);
            check_val("t2_parity_bit", 32'(line_log[9]), 32'(t));
            check_val("t2_busy_cycles", 32'(busy_cnt), 32'd11);
        end

        // 3: valid held across three frames, no gap between them
        seq3[0] = 8'h55;
        seq3[1] = 8'hFF;
        seq3[2] = 8'h00;
        k = 0;
        set_in(seq3[0], 1'b1, 1'b0, 1'b0, 1'b0);
        clear_log();
        for (int c = 0; c < 30; c++) begin
            tick();
            if (accepted) begin
                k++;
                if (k < 3) P_DATA = seq3[k];
                else DATA_VALID = 1'b0;
            end
        end
        DATA_VALID = 1'b0;
        check_val("t3_accepts", 32'(k), 32'd3);
        check_val("t3_busy_cycles", 32'(busy_cnt), 32'd30);
        check_val("t3_start2", 32'(line_log[10]), 32'd0);
        check_val("t3_start3", 32'(line_log[20]), 32'd0);
        run_idle(2);

        // 4: valid pulsed in DATA cycle 4 is ignored
        set_in(8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        DATA_VALID = 1'b0;
        run_idle(4);
        set_in(8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        DATA_VALID = 1'b0;
        run_idle(8);
        check_val("t4_busy_after", 32'(BUSY), 32'd0);
        check_val("t4_line_after", 32'(TX_OUT), 32'd1);

        // 5: async reset in DATA cycle 5, then a clean frame
        set_in(8'hC3, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        DATA_VALID = 1'b0;
        run_idle(5);
        assert_reset();
        run_idle(2);
        #2;
        RST = 1'b0;
        set_in(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        clear_log();
        tick();
        DATA_VALID = 1'b0;
        run_idle(12);
        check_val("t5_busy_cycles", 32'(busy_cnt), 32'd11);

`ifdef UART_TX_TWO_STOP_EN
        // 6: two stop bits
        set_in(8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
        clear_log();
        tick();
        DATA_VALID = 1'b0;
        run_idle(12);
        check_val("t6_stop1", 32'(line_log[9]), 32'd1);
        check_val("t6_stop2", 32'(line_log[10]), 32'd1);
        check_val("t6_busy_cycles", 32'(busy_cnt), 32'd11);
`endif

        // Randomised traffic; inputs change every cycle, including mid-frame
        for (int c = 0; c < 600; c++) begin
            set_in(8'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                   1'($urandom));
            if ($urandom_range(0, 4) == 0) DATA_VALID = 1'b1;
            tick();
        end
        DATA_VALID = 1'b0;
        run_idle(14);
        check_val("end_idle_busy", 32'(BUSY), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
